// File: rtl/multicycle_control.sv
// Main controller for the multicycle RV32I core: one Moore state per datapath step,
// sequencing ALU operand selects, memory port and write enables per instruction.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic [2:0] immSrc,
   output logic       pcWrite,
   output logic       irWrite,
   output logic       regWrite,
   output logic       memWrite,
   output logic       adrSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp,
   output logic [1:0] resultSrc,
   output logic       instrDone,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
      S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_TRAP
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_taken;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               7'b0000011, 7'b0100011: w_next = S_MEMADR;
               7'b0110011:             w_next = S_EXECR;
               7'b0010011:             w_next = S_EXECI;
               7'b1100011:             w_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
               7'b1101111:             w_next = S_JAL;
               7'b1100111:             w_next = S_JALR;
               7'b0110111:             w_next = S_LUI;
               7'b0010111:             w_next = S_ALUWB;
               default:                w_next = S_TRAP;
            endcase
         end
         S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECR, S_EXECI, S_LUI, S_JAL: w_next = S_ALUWB;
         S_JALR:     w_next = S_JAL;
         S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH: w_next = S_FETCH;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_FETCH;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = ~zero;
         3'b100:  w_taken = lt;
         3'b101:  w_taken = ~lt;
         3'b110:  w_taken = ltu;
         3'b111:  w_taken = ~ltu;
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: immSrc = 3'b000;
         7'b0100011:                         immSrc = 3'b001;
         7'b1100011:                         immSrc = 3'b010;
         7'b1101111:                         immSrc = 3'b011;
         7'b0110111, 7'b0010111:             immSrc = 3'b100;
         default:                            immSrc = 3'b000;
      endcase
   end

   // Outputs are forced idle while reset is high so an aborted instruction writes nothing.
   always_comb begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      adrSrc    = 1'b0;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      aluOp     = 2'b00;
      resultSrc = 2'b00;
      instrDone = 1'b0;
      illegal   = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               aluSrcB   = 2'b10;
               resultSrc = 2'b10;
            end
            S_DECODE: begin
               aluSrcA = 2'b01;
               aluSrcB = 2'b01;
            end
            S_MEMADR: begin
               aluSrcA = 2'b10;
               aluSrcB = 2'b01;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
               resultSrc = 2'b01;
               regWrite  = 1'b1;
               instrDone = 1'b1;
            end
            S_MEMWRITE: begin
               adrSrc    = 1'b1;
               memWrite  = 1'b1;
               instrDone = 1'b1;
            end
            S_EXECR: begin
               aluSrcA = 2'b10;
               aluOp   = 2'b10;
            end
            S_EXECI: begin
               aluSrcA = 2'b10;
               aluSrcB = 2'b01;
               aluOp   = 2'b10;
            end
            S_LUI: begin
               aluSrcA = 2'b11;
               aluSrcB = 2'b01;
            end
            S_ALUWB: begin
               regWrite  = 1'b1;
               instrDone = 1'b1;
            end
            S_BRANCH: begin
               aluSrcA   = 2'b10;
               aluOp     = 2'b01;
               pcWrite   = w_taken;
               instrDone = 1'b1;
            end
            S_JALR: begin
               aluSrcA = 2'b10;
               aluSrcB = 2'b01;
            end
            // PC takes ALUOut (branch-style target or rs1+imm from JALR) while ALU forms oldPC+4.
            S_JAL: begin
               aluSrcA = 2'b01;
               aluSrcB = 2'b10;
               pcWrite = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control sequences built from
// instruction-class tables, driven with directed and randomized instructions.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero, lt, ltu;
   logic [2:0] immSrc;
   logic       pcWrite, irWrite, regWrite, memWrite, adrSrc, instrDone, illegal;
   logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc;

   int checks = 0;
   int errors = 0;
   logic [14:0] q[$];
   logic [14:0] obs;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
      .immSrc(immSrc), .pcWrite(pcWrite), .irWrite(irWrite), .regWrite(regWrite),
      .memWrite(memWrite), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .aluOp(aluOp), .resultSrc(resultSrc), .instrDone(instrDone), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign obs = {pcWrite, irWrite, regWrite, memWrite, adrSrc, aluSrcA, aluSrcB,
                 aluOp, resultSrc, instrDone, illegal};

   // Field order: pcW irW regW memW adr A B aluOp res done ill
   localparam logic [14:0] V_IDLE   = 15'b0;
   localparam logic [14:0] V_FETCH  = {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
   localparam logic [14:0] V_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_MEMRD  = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_MEMWB  = {1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,1'b1,1'b0};
   localparam logic [14:0] V_MEMWR  = {1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [14:0] V_EXECR  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_EXECI  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_LUI    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_ALUWB  = {1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [14:0] V_BRNT   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,1'b1,1'b0};
   localparam logic [14:0] V_BRT    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,1'b1,1'b0};
   localparam logic [14:0] V_JALR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_JAL    = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,2'b00,1'b0,1'b0};
   localparam logic [14:0] V_TRAP   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1};

   function automatic logic [2:0] imm_ref(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b0010011, 7'b1100111: return 3'd0;
         7'b0100011:                         return 3'd1;
         7'b1100011:                         return 3'd2;
         7'b1101111:                         return 3'd3;
         7'b0110111, 7'b0010111:             return 3'd4;
         default:                            return 3'd0;
      endcase
   endfunction

   function automatic logic taken_ref(input logic [2:0] f, input logic z, l, lu);
      logic t;
      case (f)
         3'd0: t = z;   3'd1: t = !z;
         3'd4: t = l;   3'd5: t = !l;
         3'd6: t = lu;  3'd7: t = !lu;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Expected per-cycle control vectors for one instruction, FETCH through completion.
   task automatic build(input logic [6:0] o, input logic [2:0] f, input logic z, l, lu);
      q.delete();
      q.push_back(V_FETCH);
      q.push_back(V_DECODE);
      case (o)
         7'b0000011: begin q.push_back(V_MEMADR); q.push_back(V_MEMRD); q.push_back(V_MEMWB); end
         7'b0100011: begin q.push_back(V_MEMADR); q.push_back(V_MEMWR); end
         7'b0110011: begin q.push_back(V_EXECR); q.push_back(V_ALUWB); end
         7'b0010011: begin q.push_back(V_EXECI); q.push_back(V_ALUWB); end
         7'b1100011: begin
            if (f == 3'd2 || f == 3'd3) for (int i = 0; i < 12; i++) q.push_back(V_TRAP);
            else q.push_back(taken_ref(f, z, l, lu) ? V_BRT : V_BRNT);
         end
         7'b1101111: begin q.push_back(V_JAL); q.push_back(V_ALUWB); end
         7'b1100111: begin q.push_back(V_JALR); q.push_back(V_JAL); q.push_back(V_ALUWB); end
         7'b0110111: begin q.push_back(V_LUI); q.push_back(V_ALUWB); end
         7'b0010111: q.push_back(V_ALUWB);
         default: for (int i = 0; i < 12; i++) q.push_back(V_TRAP);
      endcase
   endtask

   task automatic chk(input string tag, input logic [14:0] o, input logic [14:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Called at posedge+1; checks n cycles of expected vectors (n<0 means whole queue).
   task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f,
                      input logic z, l, lu, input int n);
      int lim;
      op = o; funct3 = f; zero = z; lt = l; ltu = lu;
      build(o, f, z, l, lu);
      lim = (n < 0) ? q.size() : n;
      for (int i = 0; i < lim; i++) begin
         #1;
         chk($sformatf("%s_c%0d", tag, i), obs, q[i]);
         chk($sformatf("%s_imm_c%0d", tag, i), {12'b0, immSrc}, {12'b0, imm_ref(o)});
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input string tag, input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         chk($sformatf("%s_rst_c%0d", tag, i), obs, V_IDLE);
         @(posedge clk); #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      logic [6:0] ops [9];
      logic [2:0] bf [6];
      logic [6:0] o;
      logic [2:0] f;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      reset = 1'b1; op = '0; funct3 = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      @(posedge clk); #1;
      do_reset("init", 2);

      run("lw",   7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, -1);
      run("sw",   7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, -1);
      run("beq",  7'b1100011, 3'd0, 1'b1, 1'b0, 1'b0, -1);
      run("bne",  7'b1100011, 3'd1, 1'b1, 1'b0, 1'b0, -1);
      run("bltu", 7'b1100011, 3'd6, 1'b0, 1'b0, 1'b1, -1);
      run("jalr", 7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, -1);
      run("lui",  7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, -1);
      run("auipc",7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, -1);

      run("lw_abort", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 3);
      do_reset("memread", 3);
      run("lw_after", 7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, -1);

      for (int k = 0; k < 60; k++) begin
         o = ops[$urandom_range(0, 8)];
         f = (o == 7'b1100011) ? bf[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
         run($sformatf("rnd%0d", k), o, f, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      end

      run("trap_op0", 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, -1);
      do_reset("trap0", 1);
      run("post_trap0", 7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, -1);
      run("trap_br010", 7'b1100011, 3'd2, 1'b1, 1'b1, 1'b1, -1);
      do_reset("trap1", 1);
      run("post_trap1", 7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main controller for the multicycle RV32I core. It sequences the shared ALU, the memory port, and the IR, PC and register-file write enables one instruction at a time. It drives `immSrc` to the Decode-stage immediate extender. It sits beside the Decode stage and takes `op`/`funct3` from the instruction register and branch flags from the ALU.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `op`  in  7  instr[6:0] from IR
- `funct3`  in  3  instr[14:12] from IR
- `zero`, `lt`, `ltu`  in  1 each  ALU flags for rs1−rs2: equal, signed less-than, unsigned less-than
- `immSrc`  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- `pcWrite`, `irWrite`, `regWrite`, `memWrite`  out  1 each  write enables
- `adrSrc`  out  1  memory address: 0 PC, 1 ALUOut
- `aluSrcA`  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- `aluSrcB`  out  2  00 rs2, 01 immext, 10 const 4
- `aluOp`  out  2  00 add, 01 subtract/compare, 10 funct-decoded (external ALU decoder)
- `resultSrc`  out  2  00 ALUOut, 01 read data, 10 ALUResult
- `instrDone`  out  1  high in the final cycle of each retired instruction
- `illegal`  out  1  high while in TRAP

## Operation
- **immSrc** is combinational from `op` in every state:
  - 0000011, 0010011, 1100111 → 000
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111, 0010111 → 100
  - anything else → 000
- **Per-state outputs.** All unlisted outputs are 0.
  - FETCH: adrSrc0, irWrite, A00, B10, aluOp00, resultSrc10, pcWrite
  - DECODE: A01, B01, aluOp00. ALUOut ← oldPC+imm, used as branch/JAL target and AUIPC result.
  - MEMADR: A10, B01, aluOp00
  - MEMREAD: adrSrc1, resultSrc00
  - MEMWB: resultSrc01, regWrite, instrDone
  - MEMWRITE: adrSrc1, resultSrc00, memWrite, instrDone
  - EXECR: A10, B00, aluOp10
  - EXECI: A10, B01, aluOp10
  - LUI: A11, B01, aluOp00
  - ALUWB: resultSrc00, regWrite, instrDone
  - BRANCH: A10, B00, aluOp01, resultSrc00, pcWrite=taken, instrDone
  - JALR: A10, B01, aluOp00
  - JAL: A01, B10, aluOp00, resultSrc00, pcWrite
  - TRAP: illegal
- **Branch taken** (funct3 → condition):
  - 000 → zero
  - 001 → !zero
  - 100 → lt
  - 101 → !lt
  - 110 → ltu
  - 111 → !ltu
- **Transitions:**
  - FETCH → DECODE
  - DECODE, by op:
    - load/store → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → ALUWB
    - else → TRAP
  - MEMADR → MEMREAD (load) or MEMWRITE (store); MEMREAD → MEMWB
  - EXECR, EXECI, LUI, JAL → ALUWB
  - JALR → JAL. JAL writes PC from ALUOut (rs1+imm) while computing oldPC+4 for the link. The datapath clears PC bit 0.
  - MEMWB, MEMWRITE, ALUWB, BRANCH → FETCH
  - TRAP → TRAP until reset
- **Illegal instructions:** branch funct3 010/011 in DECODE → TRAP. Unsupported funct3 of load/store/ALU ops is the datapath decoder's concern, not checked here.

## Timing
- Moore outputs, a function of the state register only; `immSrc` and `pcWrite` in BRANCH also use inputs combinationally.
- While `reset` is high:
  - all write enables, `instrDone` and `illegal` are 0
  - selects are 0
  - state ← FETCH at the edge
- First FETCH is the first cycle after `reset` falls.
- `reset` asserted mid-instruction aborts it. No enable is asserted in that cycle; next state is FETCH.
- Cycles per instruction, counted FETCH through the `instrDone` cycle:
  - load 5, JALR 5
  - store 4, R 4, I 4, JAL 4, LUI 4
  - branch 3, AUIPC 3
- Exactly one `instrDone` per retired instruction. None in TRAP.
- Flags are sampled only in BRANCH and must be valid that cycle.

## Test plan
- Reset held 3 cycles mid-MEMREAD → enables 0 during reset; FETCH in first post-reset cycle with irWrite=1, pcWrite=1, A=00, B=10.
- lw (op 0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regWrite=1 and resultSrc=01 only in cycle 5; immSrc=000.
- sw (0100011) → 4 cycles; memWrite=1 only in cycle 4 with adrSrc=1; immSrc=001; regWrite never 1.
- beq with zero=1, then bne with zero=1 → 3 cycles each; pcWrite=1 in BRANCH for beq, 0 for bne; bltu with ltu=1 → taken; immSrc=010.
- jalr (1100111) → 5 cycles JALR, JAL, ALUWB; pcWrite in JAL with resultSrc=00; lui → A=11, B=01, immSrc=100; auipc → 3 cycles.
- op 0000000, then branch funct3=010 → TRAP, illegal=1 held for 10+ cycles with no enables; reset → FETCH, illegal=0.
